// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD arbiter slice.
package gcd_pkg;

    localparam int GCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/gcd_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr_i, wrapping at N_REQ.
module gcd_rr_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0] gnt_idx_o,
    output logic             any_o
);

    logic [IDX_W:0]   sum_s;
    logic [IDX_W-1:0] cand_s;
    logic             found_s;
    logic             hit_s;

    assign any_o = |req_valid_i;

    // Scan upward from the pointer; the wrap is explicit so N_REQ need not be a power of two.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        cand_s    = '0;
        hit_s     = 1'b0;
        for (int off = 0; off < N_REQ; off++) begin
            sum_s  = {1'b0, rr_ptr_i} + (IDX_W+1)'(off);
            cand_s = (sum_s >= (IDX_W+1)'(N_REQ)) ? IDX_W'(sum_s - (IDX_W+1)'(N_REQ))
                                                  : IDX_W'(sum_s);
            hit_s  = ~found_s & req_valid_i[cand_s];
            gnt_oh_o[cand_s] = gnt_oh_o[cand_s] | hit_s;
            gnt_idx_o        = hit_s ? cand_s : gnt_idx_o;
            found_s          = found_s | hit_s;
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD engine between N_REQ requesters.
// Optional engine-wait timeout is enabled by defining GCD_ARB_TIMEOUT_EN.
module gcd_arbiter
    import gcd_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int W           = GCD_W,
    parameter int TIMEOUT_CYC = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   req_ready,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_res,
    output logic               rsp_err,
    output logic               eng_start,
    output logic [W-1:0]       eng_a,
    output logic [W-1:0]       eng_b,
    input  logic               eng_done,
    input  logic [W-1:0]       eng_res,
    output logic               busy
);

    localparam int IDX_W = $clog2(N_REQ);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] pick_idx_s;
    logic [N_REQ-1:0] pick_oh_s;
    logic             pick_any_s;
    logic [N_REQ-1:0] req_ready_s;
    logic [W-1:0]     sel_a_s, sel_b_s;
    logic [W-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic             err_q, err_d;
    logic             tmo_s;
    logic [N_REQ-1:0] rsp_valid_d, rsp_valid_q;
    logic [W-1:0]     rsp_res_d, rsp_res_q;
    logic             rsp_err_d, rsp_err_q;
    logic             eng_start_q;
    logic             busy_q;

    gcd_rr_picker #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_valid_i (req_valid),
        .rr_ptr_i    (rr_ptr_q),
        .gnt_oh_o    (pick_oh_s),
        .gnt_idx_o   (pick_idx_s),
        .any_o       (pick_any_s)
    );

    // AND-OR mux of the picked requester's operands.
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sel_a_s = sel_a_s | ({W{pick_oh_s[i]}} & req_a[i*W +: W]);
            sel_b_s = sel_b_s | ({W{pick_oh_s[i]}} & req_b[i*W +: W]);
        end
    end

`ifdef GCD_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt_q;

    // Counts WAIT cycles; held at zero elsewhere so every WAIT entry starts from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_q <= 8'd0;
        end
    end

    assign tmo_s = (state_q == WAIT) && (wait_cnt_q == 8'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo_s;

    assign unused_tmo_s = ^TIMEOUT_CYC;
    assign tmo_s        = 1'b0;
`endif

    // Next-state and datapath-register logic; req_ready is a same-cycle strobe in IDLE.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        err_d       = err_q;
        req_ready_s = '0;
        case (state_q)
            IDLE: begin
                if (pick_any_s) begin
                    req_ready_s = pick_oh_s;
                    a_d         = sel_a_s;
                    b_d         = sel_b_s;
                    gnt_d       = pick_idx_s;
                    err_d       = 1'b0;
                    // A zero operand makes the answer the other operand; skip the engine.
                    if ((sel_a_s == '0) || (sel_b_s == '0)) begin
                        res_d   = sel_a_s | sel_b_s;
                        state_d = RESP;
                    end else begin
                        res_d   = '0;
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    res_d   = eng_res;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo_s) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                rr_ptr_d = (gnt_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response outputs are precomputed from the next state so they come straight from flops.
    always_comb begin
        rsp_valid_d = '0;
        rsp_res_d   = '0;
        rsp_err_d   = 1'b0;
        if (state_d == RESP) begin
            for (int i = 0; i < N_REQ; i++) begin
                rsp_valid_d[i] = (gnt_d == IDX_W'(i));
            end
            rsp_res_d = res_d;
            rsp_err_d = err_d;
        end else begin
            rsp_valid_d = '0;
        end
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            err_q       <= 1'b0;
            rsp_valid_q <= '0;
            rsp_res_q   <= '0;
            rsp_err_q   <= 1'b0;
            eng_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            err_q       <= err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_res_q   <= rsp_res_d;
            rsp_err_q   <= rsp_err_d;
            eng_start_q <= (state_d == ISSUE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign req_ready = req_ready_s;
    assign rsp_valid = rsp_valid_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_err   = rsp_err_q;
    assign eng_start = eng_start_q;
    assign eng_a     = a_q;
    assign eng_b     = b_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Scoreboard bench for gcd_arbiter: a 4-requester instance with an engine model and a
// 3-requester instance for the non-power-of-two wrap case.
module tb_gcd_arbiter;

    localparam int N  = 4;
    localparam int N3 = 3;
    localparam int W  = 4;

    typedef struct {
        int dut;
        int idx;
        int res;
        int err;
        int cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, rsp_valid;
    logic [N*W-1:0]   req_a, req_b;
    logic [W-1:0]     rsp_res, eng_a, eng_b, eng_res;
    logic             rsp_err, eng_start, eng_done, busy;

    logic [N3-1:0]    req_valid3, req_ready3, rsp_valid3;
    logic [N3*W-1:0]  req_a3, req_b3;
    logic [W-1:0]     rsp_res3, eng_a3, eng_b3;
    logic             rsp_err3, eng_start3, busy3;

    exp_t sb[$];
    int   n_cmp   = 0;
    int   n_err   = 0;
    int   cyc     = 0;
    int   n_start = 0;
    int   eng_lat = 3;
    int   eng_cnt = 0;

    always #5 clk = ~clk;

    gcd_arbiter #(.N_REQ(N), .W(W), .TIMEOUT_CYC(32)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .eng_start(eng_start), .eng_a(eng_a), .eng_b(eng_b), .eng_done(eng_done),
        .eng_res(eng_res), .busy(busy)
    );

    gcd_arbiter #(.N_REQ(N3), .W(W), .TIMEOUT_CYC(32)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_res(rsp_res3), .rsp_err(rsp_err3),
        .eng_start(eng_start3), .eng_a(eng_a3), .eng_b(eng_b3), .eng_done(1'b0),
        .eng_res(4'd0), .busy(busy3)
    );

    function automatic int gcd_f(input int a, input int b);
        int x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Engine model: answers gcd(eng_a, eng_b) eng_lat cycles after start; eng_lat 0 never answers.
    initial begin
        eng_done = 1'b0;
        eng_res  = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_res  = W'(gcd_f(int'(eng_a), int'(eng_b)));
                end
            end
            if (eng_start) begin
                n_start++;
                eng_cnt = eng_lat;
            end
        end
    end

    // Monitor: pops the scoreboard on every response pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid != '0 || rsp_valid3 != '0) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b rsp_valid3=%b, nothing expected (cycle %0d)",
                             rsp_valid, rsp_valid3, cyc);
                end else begin
                    e = sb.pop_front();
                    if (e.dut == 0) begin
                        check("rsp_valid", int'(rsp_valid), 1 << e.idx);
                        check("rsp_res", int'(rsp_res), e.res);
                        check("rsp_err", int'(rsp_err), e.err);
                        check("rsp_valid3_quiet", int'(rsp_valid3), 0);
                    end else begin
                        check("rsp_valid3", int'(rsp_valid3), 1 << e.idx);
                        check("rsp_res3", int'(rsp_res3), e.res);
                        check("rsp_err3", int'(rsp_err3), e.err);
                        check("rsp_valid_quiet", int'(rsp_valid), 0);
                    end
                    check("rsp_cycle", cyc, e.cyc);
                end
            end else begin
                check("idle_rsp_res", int'(rsp_res), 0);
                check("idle_rsp_err", int'(rsp_err), 0);
                check("idle_rsp_res3", int'(rsp_res3), 0);
            end
            check("eng_start3_never", int'(eng_start3), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic wait_grant(input int dut, output int idx, output int t);
        logic [N-1:0] rdy;
        idx = -1;
        t   = -1;
        for (int k = 0; k < 80; k++) begin
            #1;
            rdy = (dut == 0) ? req_ready : {1'b0, req_ready3};
            if (rdy != '0) begin
                check("ready_onehot", $countones(rdy), 1);
                for (int i = 0; i < N; i++) begin
                    if (rdy[i]) idx = i;
                end
                t = cyc;
                break;
            end
            @(negedge clk);
        end
        if (idx < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_timeout: got no req_ready, required a grant (dut %0d)", dut);
        end
    endtask

    task automatic issue(input int dut, input int idx, input int a, input int b, input int k,
                         input int exp_res, input int exp_err, input int rsp_off, input int push);
        int g, t;
        eng_lat = k;
        if (dut == 0) begin
            req_a[idx*W +: W] = W'(a);
            req_b[idx*W +: W] = W'(b);
            req_valid[idx]    = 1'b1;
        end else begin
            req_a3[idx*W +: W] = W'(a);
            req_b3[idx*W +: W] = W'(b);
            req_valid3[idx]    = 1'b1;
        end
        wait_grant(dut, g, t);
        check("grant_idx", g, idx);
        if (push != 0) sb.push_back('{dut, idx, exp_res, exp_err, t + rsp_off});
        @(negedge clk);
        req_valid  = '0;
        req_valid3 = '0;
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !busy3) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int g, t, s0;
        int rr_res[4];
        rr_res = '{4, 3, 5, 7};
        rst = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0;
        req_valid3 = '0; req_a3 = '0; req_b3 = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_rsp_valid", int'(rsp_valid), 0);
        check("rst_eng_start", int'(eng_start), 0);
        check("rst_eng_a", int'(eng_a), 0);
        check("rst_eng_b", int'(eng_b), 0);
        check("rst_req_ready", int'(req_ready), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request, engine answers after 3 cycles.
        s0 = n_start;
        issue(0, 0, 12, 8, 3, 4, 0, 5, 1);
        check("issue_eng_start", int'(eng_start), 1);
        check("issue_eng_a", int'(eng_a), 12);
        check("issue_eng_b", int'(eng_b), 8);
        drain();
        check("single_start_count", n_start - s0, 1);

        // Round-robin with all four requesters held valid.
        do_reset();
        s0 = n_start;
        eng_lat = 2;
        req_a = {4'd14, 4'd10, 4'd9, 4'd12};
        req_b = {4'd7, 4'd15, 4'd6, 4'd8};
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(0, g, t);
            check("rr_grant", g, i % 4);
            sb.push_back('{0, i % 4, rr_res[i % 4], 0, t + 4});
            @(negedge clk);
        end
        req_valid = '0;
        drain();
        check("rr_start_count", n_start - s0, 5);

        // Zero-operand bypass never touches the engine.
        s0 = n_start;
        issue(0, 2, 0, 9, 2, 9, 0, 1, 1);
        drain();
        issue(0, 3, 5, 0, 2, 5, 0, 1, 1);
        drain();
        issue(0, 1, 0, 0, 2, 0, 0, 1, 1);
        drain();
        check("bypass_start_count", n_start - s0, 0);

        // Reset during WAIT: no response, late eng_done ignored, pointer back to 0.
        issue(0, 3, 6, 4, 10, 2, 0, 0, 0);
        @(negedge clk);
        check("wait_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_rsp_valid", int'(rsp_valid), 0);
        check("midrst_eng_start", int'(eng_start), 0);
        check("midrst_eng_a", int'(eng_a), 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("late_done_busy", int'(busy), 0);
        req_a = {4'd0, 4'd0, 4'd0, 4'd0};
        req_b = {4'd2, 4'd0, 4'd6, 4'd0};
        req_valid = 4'b1010;
        wait_grant(0, g, t);
        check("ptr_after_rst_grant", g, 1);
        sb.push_back('{0, 1, 6, 0, t + 1});
        @(negedge clk);
        req_valid[1] = 1'b0;
        wait_grant(0, g, t);
        check("ptr_next_grant", g, 3);
        sb.push_back('{0, 3, 2, 0, t + 1});
        @(negedge clk);
        req_valid = '0;
        drain();

        // eng_done on the last permitted WAIT cycle gives a normal result.
        issue(0, 0, 12, 9, 32, 3, 0, 34, 1);
        drain();

`ifdef GCD_ARB_TIMEOUT_EN
        issue(0, 1, 8, 12, 0, 0, 1, 34, 1);
        drain();
`else
        issue(0, 1, 8, 12, 0, 0, 0, 0, 0);
        repeat (60) @(negedge clk);
        check("hang_busy_holds", int'(busy), 1);
        do_reset();
        check("hang_reset_busy", int'(busy), 0);
`endif

        // Three requesters: pointer at 2 with req0 and req2 pending picks 2, then 0.
        issue(1, 1, 0, 3, 0, 3, 0, 1, 1);
        drain();
        req_a3 = {4'd7, 4'd0, 4'd0};
        req_b3 = {4'd0, 4'd0, 4'd0};
        req_valid3 = 3'b101;
        wait_grant(1, g, t);
        check("wrap3_grant", g, 2);
        sb.push_back('{1, 2, 7, 0, t + 1});
        @(negedge clk);
        req_valid3[2] = 1'b0;
        wait_grant(1, g, t);
        check("wrap3_next_grant", g, 0);
        sb.push_back('{1, 0, 0, 0, t + 1});
        @(negedge clk);
        req_valid3 = '0;
        drain();

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
